// File: rtl/inner_product_seq_ctrl_pkg.sv
// Shared definitions for the sequenced inner-product engine: FSM encodings
// and default element geometry.
package inner_product_seq_ctrl_pkg;

  localparam int N_ELEM_DEF = 3;
  localparam int WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Result width that cannot overflow when summing n full-scale products
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/inner_product_seq_ctrl_if.sv
// Operand/result handshake bundle of the inner-product engine; the engine
// uses the slave modport, the operand source / result sink the master one.
interface inner_product_seq_ctrl_if
  import inner_product_seq_ctrl_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ACC_W  = acc_width(N_ELEM, WIDTH)
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [N_ELEM*WIDTH-1:0]   a;
  logic [N_ELEM*WIDTH-1:0]   b;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          p;
  logic                      busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

endinterface

// File: rtl/inner_product_seq_ctrl_mul.sv
// Radix-4 Booth 8x8 signed multiplier (combinational); the single multiplier
// time-shared by the inner-product engine.
module inner_product_seq_ctrl_mul (
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  output logic signed [15:0] prod
);

  logic [8:0]         rec_s;
  logic signed [15:0] a_ext_s;
  logic signed [15:0] pp_s;
  logic signed [15:0] sum_s;

  assign rec_s   = {b, 1'b0};
  assign a_ext_s = {{8{a[7]}}, a};

  // Recode b into four Booth digits in {-2..+2} and sum the shifted partial products
  always_comb begin
    sum_s = 16'sd0;
    pp_s  = 16'sd0;
    for (int i = 0; i < 4; i++) begin
      case (rec_s[2*i +: 3])
        3'b001, 3'b010: pp_s = a_ext_s;
        3'b011:         pp_s = a_ext_s <<< 1;
        3'b100:         pp_s = -(a_ext_s <<< 1);
        3'b101, 3'b110: pp_s = -a_ext_s;
        default:        pp_s = 16'sd0;
      endcase
      sum_s = sum_s + (pp_s <<< (2 * i));
    end
    prod = sum_s;
  end

endmodule

// File: rtl/inner_product_seq_ctrl.sv
// Sequenced inner product: one shared Booth multiplier walks the N_ELEM pairs.
// Optional IP_MUL_PIPE_EN registers the multiplier output and adds a FLUSH state.
module inner_product_seq_ctrl
  import inner_product_seq_ctrl_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int WIDTH  = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  inner_product_seq_ctrl_if.slave  bus
);

  localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int ACC_W  = acc_width(N_ELEM, WIDTH);
  localparam int PROD_W = 2 * WIDTH;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [IDX_W-1:0]         idx_r;
  logic [N_ELEM*WIDTH-1:0]  a_r;
  logic [N_ELEM*WIDTH-1:0]  b_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_nxt_s;
  logic signed [ACC_W-1:0]  addend_s;
  logic [ACC_W-1:0]         p_r;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic                     busy_r;
  logic [WIDTH-1:0]         a_elem_s;
  logic [WIDTH-1:0]         b_elem_s;
  logic signed [PROD_W-1:0] prod_s;
  logic                     accept_s;
  logic                     release_s;
  logic                     last_s;

  assign accept_s  = bus.in_valid  && (state_r == ST_IDLE);
  assign release_s = bus.out_ready && (state_r == ST_DONE);
  assign last_s    = (idx_r == IDX_W'(N_ELEM - 1));

  // Element select from the captured vectors
  always_comb begin
    a_elem_s = a_r[int'(idx_r) * WIDTH +: WIDTH];
    b_elem_s = b_r[int'(idx_r) * WIDTH +: WIDTH];
  end

  inner_product_seq_ctrl_mul u_mul (
    .a    (a_elem_s),
    .b    (b_elem_s),
    .prod (prod_s)
  );

`ifdef IP_MUL_PIPE_EN
  logic signed [PROD_W-1:0] prod_r;

  // Product pipeline register; zero outside BUSY so the first BUSY cycle adds nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r <= {PROD_W{1'b0}};
    end else if (state_r == ST_BUSY) begin
      prod_r <= prod_s;
    end else begin
      prod_r <= {PROD_W{1'b0}};
    end
  end

  assign addend_s = {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r};
`else
  assign addend_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
`endif

  assign acc_nxt_s = acc_r + addend_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_BUSY;
        else          state_nxt_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (last_s) begin
`ifdef IP_MUL_PIPE_EN
          state_nxt_s = ST_FLUSH;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
`ifdef IP_MUL_PIPE_EN
      ST_FLUSH: state_nxt_s = ST_DONE;
`else
      ST_FLUSH: state_nxt_s = ST_IDLE;
`endif
      ST_DONE: begin
        if (release_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake/status flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s == ST_BUSY) || (state_nxt_s == ST_FLUSH);
    end
  end

  // Operand capture, element counter, accumulator and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
      acc_r <= {ACC_W{1'b0}};
      a_r   <= {(N_ELEM*WIDTH){1'b0}};
      b_r   <= {(N_ELEM*WIDTH){1'b0}};
      p_r   <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          idx_r <= {IDX_W{1'b0}};
          acc_r <= {ACC_W{1'b0}};
          if (accept_s) begin
            a_r <= bus.a;
            b_r <= bus.b;
          end
        end
        ST_BUSY: begin
          acc_r <= acc_nxt_s;
          idx_r <= last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end
        ST_FLUSH: acc_r <= acc_nxt_s;
        ST_DONE:  acc_r <= acc_r;
        default:  acc_r <= {ACC_W{1'b0}};
      endcase
      // The result is latched once, on the edge that enters DONE, and held there
      if ((state_nxt_s == ST_DONE) && (state_r != ST_DONE)) begin
        p_r <= acc_nxt_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.p         = p_r;

endmodule
